riscvssc_imem_arbiter: RTL

- Merges the core's two instruction-fetch request ports (imemreq0, imemreq1) onto one single-ported instruction memory, and routes each in-order memory response back to the port that issued it.
- Sits directly downstream of the dual-issue core's imem ports, in place of the two separate imem channels in the test harness.
- Uses round-robin arbitration and a tag FIFO of outstanding requests; a full FIFO provides back-pressure.

---
 rtl/riscvssc_imem_arbiter_pkg.sv | 31 +++
 rtl/riscvssc_tag_fifo.sv | 75 +++++++
 rtl/riscvssc_imem_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/riscvssc_imem_arbiter_pkg.sv
// Shared constants and types for the dual-port instruction-fetch arbiter.
// Message widths match the vc memory message formats:
//   request  = {type(1), addr(32), len(2), data(32)}
//   response = {type(1), len(2), data(32)}
package riscvssc_imem_arbiter_pkg;

    localparam int unsigned MEM_REQ_MSG_SZ  = 67;
    localparam int unsigned MEM_RESP_MSG_SZ = 35;

    // Default number of requests that may be in flight to memory.
    localparam int unsigned IMEM_ARB_DEPTH = 4;

    // Identifies which fetch port issued a request.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    // Round-robin pick: a lone requester always wins; under contention the
    // port that did not win last time gets the grant.
    function automatic port_id_e rr_pick(input logic v0, input logic v1,
                                         input port_id_e last);
        if (v0 && v1) begin
            return (last == PORT0) ? PORT1 : PORT0;
        end else if (v1) begin
            return PORT1;
        end
        return PORT0;
    endfunction

endpackage

// File: rtl/riscvssc_tag_fifo.sv
// 1-bit-wide tag FIFO remembering which port owns each outstanding memory
// request. Memory responses come back in order, so the head always names the
// port the next response belongs to.
module riscvssc_tag_fifo
    import riscvssc_imem_arbiter_pkg::*;
#(
    parameter int unsigned p_depth  = IMEM_ARB_DEPTH,
    parameter int unsigned p_ptr_sz = $clog2(p_depth)
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  port_id_e push_data_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output port_id_e head_data_o
);

    localparam logic [p_ptr_sz-1:0] PTR_ONE   = p_ptr_sz'(1);
    localparam logic [p_ptr_sz:0]   CNT_ONE   = (p_ptr_sz + 1)'(1);
    localparam logic [p_ptr_sz:0]   CNT_DEPTH = (p_ptr_sz + 1)'(p_depth);

    port_id_e            mem_q [p_depth];
    logic [p_ptr_sz-1:0] head_q, head_d;
    logic [p_ptr_sz-1:0] tail_q, tail_d;
    logic [p_ptr_sz:0]   count_q, count_d;
    logic                push_ok;
    logic                pop_ok;

    assign full_o      = (count_q == CNT_DEPTH);
    assign empty_o     = (count_q == '0);
    assign head_data_o = mem_q[head_q];

    // A push into a full FIFO is refused even when a pop frees a slot in the
    // same cycle; the arbiter never attempts one, this keeps the FIFO safe alone.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + PTR_ONE;
        if (pop_ok)  head_d = head_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tag storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; only entries below count are ever read.
        if (push_ok) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/riscvssc_imem_arbiter.sv
// Merges the core's two instruction-fetch ports onto one memory port with
// round-robin arbitration, and routes each in-order response back to the
// port that issued it. Both paths are purely combinational.
module riscvssc_imem_arbiter
    import riscvssc_imem_arbiter_pkg::*;
#(
    parameter int unsigned p_depth  = IMEM_ARB_DEPTH,
    parameter int unsigned p_ptr_sz = $clog2(p_depth)
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [MEM_REQ_MSG_SZ-1:0]  imemreq0_msg,
    input  logic                       imemreq0_val,
    output logic                       imemreq0_rdy,
    output logic [MEM_RESP_MSG_SZ-1:0] imemresp0_msg,
    output logic                       imemresp0_val,

    input  logic [MEM_REQ_MSG_SZ-1:0]  imemreq1_msg,
    input  logic                       imemreq1_val,
    output logic                       imemreq1_rdy,
    output logic [MEM_RESP_MSG_SZ-1:0] imemresp1_msg,
    output logic                       imemresp1_val,

    output logic [MEM_REQ_MSG_SZ-1:0]  memreq_msg,
    output logic                       memreq_val,
    input  logic                       memreq_rdy,
    input  logic [MEM_RESP_MSG_SZ-1:0] memresp_msg,
    input  logic                       memresp_val,

    output logic                       err
);

    port_id_e last_grant_q, last_grant_d;
    logic     err_q, err_d;
    port_id_e grant;
    port_id_e head_id;
    logic     full;
    logic     empty;
    logic     fire;
    logic     pop;

    // Request side: the grant never looks at memreq_rdy, so memreq_val does
    // not depend on it either. Outputs are held low while reset is high.
    assign grant      = rr_pick(imemreq0_val, imemreq1_val, last_grant_q);
    assign memreq_val = (imemreq0_val | imemreq1_val) & ~full & ~reset;
    assign memreq_msg = (grant == PORT1) ? imemreq1_msg : imemreq0_msg;
    assign fire       = memreq_val & memreq_rdy;

    assign imemreq0_rdy = fire & (grant == PORT0);
    assign imemreq1_rdy = fire & (grant == PORT1);

    // Response side: the FIFO head names the owner of the incoming response.
    // A response with nothing outstanding is dropped and flagged.
    assign pop           = memresp_val & ~empty & ~reset;
    assign imemresp0_val = pop & (head_id == PORT0);
    assign imemresp1_val = pop & (head_id == PORT1);
    assign imemresp0_msg = memresp_msg;
    assign imemresp1_msg = memresp_msg;
    assign err           = err_q;

    riscvssc_tag_fifo #(
        .p_depth  (p_depth),
        .p_ptr_sz (p_ptr_sz)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fire),
        .push_data_i (grant),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_data_o (head_id)
    );

    // Next-state for the round-robin pointer and the sticky error flag.
    always_comb begin
        last_grant_d = fire ? grant : last_grant_q;
        err_d        = err_q | (memresp_val & empty);
    end

    // Arbiter state; last_grant resets to port 1 so port 0 wins first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT1;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

endmodule
